// File: rtl/pll_div_pkg.sv
// Shared constants and types for the PLL feedback divider.
// Used by the 4/5 prescaler and its modulus latch.
package pll_div_pkg;

   localparam int   DIV_LO  = 4;
   localparam int   DIV_HI  = 5;
   localparam int   CNT_W   = 3;
   localparam logic MC_DIV4 = 1'b1;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic {
      RATIO_5 = 1'b0,
      RATIO_4 = 1'b1
   } ratio_e;

   // Phase value at which the current period ends.
   function automatic cnt_t last_phase(input ratio_e r);
      return (r == RATIO_4) ? cnt_t'(DIV_LO - 1)
                            : cnt_t'(DIV_HI - 1);
   endfunction

endpackage

// File: rtl/prescaler_mod_latch.sv
// Holds the active division ratio.
// Loads the modulus control only on the period wrap strobe.
module prescaler_mod_latch
   import pll_div_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   wrap_i,
   input  logic   mc_i,
   output ratio_e ratio_o
);

   ratio_e ratio_q;
   ratio_e ratio_d;

   always_comb begin
      ratio_d = ratio_q;
      if (wrap_i) begin
         ratio_d = (mc_i == MC_DIV4) ? RATIO_4 : RATIO_5;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ratio_q <= RATIO_5;
      end else begin
         ratio_q <= ratio_d;
      end
   end

   assign ratio_o = ratio_q;

endmodule

// File: rtl/prescaler_4_5.sv
// Dual-modulus 4/5 prescaler for the fractional-N feedback path.
// Output is high for phases 0 and 1 of every period, registered.
module prescaler_4_5
   import pll_div_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic mc,
   output logic out
);

   cnt_t   cnt_q;
   cnt_t   cnt_d;
   logic   out_q;
   logic   out_d;
   logic   wrap;
   ratio_e ratio;

   prescaler_mod_latch u_mod_latch (
      .clk     (clk),
      .rst     (rst),
      .wrap_i  (wrap),
      .mc_i    (mc),
      .ratio_o (ratio)
   );

   // >= also recovers from an out-of-range phase.
   assign wrap = (cnt_q >= last_phase(ratio));

   always_comb begin
      cnt_d = wrap ? '0 : cnt_q + cnt_t'(1);
      out_d = (cnt_d <= cnt_t'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         out_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_prescaler_4_5.sv
// Self-checking bench for the 4/5 prescaler.
// Reference model builds each output period as a bit pattern.
module tb_prescaler_4_5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mc  = 1'b0;
   logic out;

   int tests = 0;
   int fails = 0;

   prescaler_4_5 dut (
      .clk (clk),
      .rst (rst),
      .mc  (mc),
      .out (out)
   );

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string nm,
                      input string act, input string exp);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %s, expected %s", nm, act, exp);
      end
   endtask

   // Model: a queue of upcoming output bits. When it runs dry the
   // period ends, mc is sampled and a fresh 2-high pattern is queued.
   logic exp_out;
   logic q[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         q.push_back(1'b1);
         q.push_back(1'b0);
         q.push_back(1'b0);
         q.push_back(1'b0);
         exp_out <= 1'b0;
      end else begin
         if (q.size() == 0) begin
            int n;
            n = mc ? 4 : 5;
            for (int k = 0; k < n; k++) q.push_back(k < 2);
         end
         exp_out <= q.pop_front();
      end
   end

   // Per-cycle compare plus period / high-phase shape checks.
   logic prev_o   = 1'b0;
   int   cyc      = 0;
   int   last_r   = 0;
   int   rises    = 0;
   int   falls    = 0;
   int   hi_len   = 0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         chk(out === 1'b0, "reset_out",
             $sformatf("%b", out), "0");
         prev_o <= 1'b0;
         rises  <= 0;
         falls  <= 0;
         hi_len <= 0;
      end else begin
         chk(out === exp_out, "model",
             $sformatf("%b", out), $sformatf("%b", exp_out));
         if (out && !prev_o) begin
            if (rises > 0)
               chk((cyc - last_r) == 4 || (cyc - last_r) == 5,
                   "period_len", $sformatf("%0d", cyc - last_r),
                   "4 or 5");
            last_r <= cyc;
            rises  <= rises + 1;
         end
         if (!out && prev_o) begin
            if (falls > 0)
               chk(hi_len == 2, "high_len",
                   $sformatf("%0d", hi_len), "2");
            falls <= falls + 1;
         end
         hi_len <= out ? hi_len + 1 : 0;
         prev_o <= out;
      end
   end

   // Drive mc per cycle (MSB first) and check literal out values.
   task automatic run_seq(input logic [31:0] mcs,
                          input logic [31:0] outs,
                          input int n, input string nm);
      for (int i = 0; i < n; i++) begin
         mc = mcs[n-1-i];
         @(negedge clk);
         chk(out === outs[n-1-i], nm,
             $sformatf("%b at step %0d", out, i),
             $sformatf("%b", outs[n-1-i]));
      end
   endtask

   initial begin
      int toggles;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_seq(32'h0,   32'b100011000110,   12, "div5_start");
      run_seq(32'hFFF, 32'b001100110011,   12, "div4_switch");
      run_seq(32'h0,   32'b0011000110,     10, "div5_back");
      run_seq(32'b100000000,
              32'b001100011,                9, "mc_pulse_mid");
      run_seq(32'b0001000000000,
              32'b0001100110001,           13, "mc_pulse_wrap");
      #2 rst = 1'b1;
      #1 chk(out === 1'b0, "async_rst_drop",
             $sformatf("%b", out), "0");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_seq(32'h0,   32'b10001,           5, "restart");
      toggles = 0;
      while (toggles < 1000) begin
         if ($urandom_range(2) == 0) begin
            mc = ~mc;
            toggles++;
         end
         @(negedge clk);
      end
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
